// File: rtl/seg_display_driver.sv
// seg_display_driver: multiplexes an MM.SS time value onto a 4-digit
// common-anode 7-segment display. Inputs are captured once per scan frame
// so a digit never shows a value that changed partway through the frame.
// The selected digit pair can be blinked while the time is being adjusted.
module seg_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] min_high,
  input  logic [3:0] min_low,
  input  logic [2:0] sec_high,
  input  logic [3:0] sec_low,
  input  logic       blink_en,
  input  logic       blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rc;
  logic [1:0]    idx;
  logic [BW-1:0] bc;
  logic          blink_phase;
  logic          tick;

  logic [2:0] snap_min_high;
  logic [3:0] snap_min_low;
  logic [2:0] snap_sec_high;
  logic [3:0] snap_sec_low;
  logic       snap_blink_en;
  logic       snap_blink_sel;

  logic [3:0] digit;
  logic       digit_is_high;
  logic       blank;
  logic [6:0] seg_dec;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign tick = (rc == RC_LAST);

  // Refresh counter and digit slot index; snapshot loads on the last cycle of slot 3
  always_ff @(posedge clk) begin
    if (rst) begin
      rc             <= '0;
      idx            <= '0;
      snap_min_high  <= '0;
      snap_min_low   <= '0;
      snap_sec_high  <= '0;
      snap_sec_low   <= '0;
      snap_blink_en  <= 1'b0;
      snap_blink_sel <= 1'b0;
    end else begin
      if (tick) begin
        rc  <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_min_high  <= min_high;
          snap_min_low   <= min_low;
          snap_sec_high  <= sec_high;
          snap_sec_low   <= sec_low;
          snap_blink_en  <= blink_en;
          snap_blink_sel <= blink_sel;
        end
      end else begin
        rc <= rc + RW'(1);
      end
    end
  end

  // Free-running blink timebase, independent of blink_en
  always_ff @(posedge clk) begin
    if (rst) begin
      bc          <= '0;
      blink_phase <= 1'b0;
    end else if (bc == BC_LAST) begin
      bc          <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      bc <= bc + BW'(1);
    end
  end

  // Select the current digit, decode it and apply blanking
  always_comb begin
    digit         = '0;
    digit_is_high = 1'b0;
    seg_dec       = 7'h3F;
    case (idx)
      2'd0: digit = snap_sec_low;
      2'd1: begin
        digit         = {1'b0, snap_sec_high};
        digit_is_high = 1'b1;
      end
      2'd2: digit = snap_min_low;
      default: begin
        digit         = {1'b0, snap_min_high};
        digit_is_high = 1'b1;
      end
    endcase

    if (!(digit_is_high && digit > 4'd5)) begin
      case (digit)
        4'd0: seg_dec = 7'h40;
        4'd1: seg_dec = 7'h79;
        4'd2: seg_dec = 7'h24;
        4'd3: seg_dec = 7'h30;
        4'd4: seg_dec = 7'h19;
        4'd5: seg_dec = 7'h12;
        4'd6: seg_dec = 7'h02;
        4'd7: seg_dec = 7'h78;
        4'd8: seg_dec = 7'h00;
        4'd9: seg_dec = 7'h10;
        default: seg_dec = 7'h3F;
      endcase
    end

    // Minutes live in slots 3,2 (idx[1]=1); seconds in slots 1,0
    blank = snap_blink_en && blink_phase && (idx[1] == ~snap_blink_sel);

    an_next  = blank ? 4'b1111 : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : seg_dec;
    dp_next  = !((idx == 2'd2) && !blank);
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Testbench for seg_display_driver: randomized inputs against a cycle-count
// based reference model, plus literal spot checks of known display values.
module tb_seg_display_driver;

  localparam int unsigned R = 4;
  localparam int unsigned B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] min_high = '0;
  logic [3:0] min_low = '0;
  logic [2:0] sec_high = '0;
  logic [3:0] sec_low = '0;
  logic       blink_en = 1'b0;
  logic       blink_sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  seg_display_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .min_high(min_high), .min_low(min_low),
    .sec_high(sec_high), .sec_low(sec_low),
    .blink_en(blink_en), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int unsigned n = 0;          // clock edges since reset released
  bit          model_ok = 0;
  int unsigned m_digit [0:3];  // snapshot, indexed by display slot
  bit          m_ben = 0, m_bsel = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge clk) begin
    int unsigned slot, v;
    bit phase, hi, blank;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 4; i++) m_digit[i] = 0;
      m_ben = 0; m_bsel = 0;
      exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
      model_ok = 1;
    end else if (model_ok) begin
      slot  = (n / R) % 4;
      phase = ((n / B) % 2) == 1;
      v     = m_digit[slot];
      hi    = (slot == 1) || (slot == 3);
      // blink_sel=0 -> minutes (slots 2,3); 1 -> seconds (slots 0,1)
      blank = m_ben && phase && ((m_bsel == 0) ? (slot >= 2) : (slot < 2));
      if (blank) begin
        exp_an = 4'b1111; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an = 4'b1111;
        exp_an[slot] = 1'b0;
        if ((hi && v > 5) || v > 9) exp_seg = 7'h3F;
        else exp_seg = seg_tab[v];
        exp_dp = (slot == 2) ? 1'b0 : 1'b1;
      end
      if (n % (4 * R) == 4 * R - 1) begin
        m_digit[0] = sec_low;  m_digit[1] = sec_high;
        m_digit[2] = min_low;  m_digit[3] = min_high;
        m_ben = blink_en;      m_bsel = blink_sel;
      end
      n++;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        errors++;
        $display("FAIL model n=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                 n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_lit(input string name, input logic [3:0] a,
                           input logic [6:0] s, input logic d);
    checks++;
    if (an !== a || seg !== s || dp !== d) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, an, seg, dp, a, s, d);
    end
  endtask

  task automatic set_in(input int mh, input int ml, input int sh, input int sl);
    min_high = 3'(mh); min_low = 4'(ml); sec_high = 3'(sh); sec_low = 4'(sl);
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  logic [6:0] exp_frame [0:3] = '{7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    // Test 1: reset with inputs 1,2,3,4
    set_in(1, 2, 3, 4);
    cycles(2);
    check_lit("reset_state", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    cycles(1);
    check_lit("first_after_reset", 4'b1110, 7'h40, 1'b1);
    cycles(15);
    check_lit("frame1_slot3", 4'b0111, 7'h40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'b1111;
      a[i] = 1'b0;
      cycles(1);
      check_lit("frame2_digit", a, exp_frame[i], (i == 2) ? 1'b0 : 1'b1);
      cycles(3);
    end
    // now after edge 32: next output is slot 0 of frame 3

    // Test 2: change sec_low while slot 1 is showing in frame 3
    cycles(5);
    set_in(1, 2, 3, 5);
    cycles(11);                            // finish frame 3 (still 4 snapshotted)
    cycles(1);
    check_lit("no_tear_new_frame", 4'b1110, 7'h12, 1'b1);
    cycles(15);

    // Test 3: out-of-range digits
    set_in(6, 2, 3, 12);
    cycles(16 * 3);

    // Test 4: blink minutes, then seconds
    set_in(1, 2, 3, 4);
    blink_en = 1'b1; blink_sel = 1'b0;
    cycles(16 * 6);
    blink_sel = 1'b1;
    cycles(16 * 6);
    blink_en = 1'b0;

    // Test 5: reset for one cycle while idx=2
    cycles(16 - (n % 16) + 8);
    rst = 1'b1;
    cycles(1);
    check_lit("mid_reset", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    cycles(1);
    check_lit("after_mid_reset", 4'b1110, 7'h40, 1'b1);
    cycles(8);
    check_lit("after_mid_reset_dp", 4'b1011, 7'h40, 1'b0);

    // Test 6: hold 5,9,5,9 for 8 frames
    set_in(5, 9, 5, 9);
    cycles(16 * 9);

    // Randomized stimulus including occasional mid-frame resets
    for (int k = 0; k < 120; k++) begin
      cycles($urandom_range(1, 24));
      if ($urandom_range(0, 3) == 0)
        set_in($urandom_range(0, 7), $urandom_range(0, 15),
               $urandom_range(0, 7), $urandom_range(0, 15));
      else
        set_in($urandom_range(0, 5), $urandom_range(0, 9),
               $urandom_range(0, 5), $urandom_range(0, 9));
      blink_en  = 1'($urandom_range(0, 1));
      blink_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
